scroll_sel_ctrl: RTL

Automatic position sequencer for the eight-digit HEX7..HEX0 message rotator. It replaces the manual 3-bit rotation select (formerly SW[17:15]) with a timed, free-running scroll position. The position can be paused, reversed, single-stepped or loaded. It sits directly upstream of the rotator, and its `sel` output drives the rotator's select input unchanged.

---
 rtl/scroll_pkg.sv | 31 +++
 rtl/tick_prescaler.sv | 31 +++
 rtl/scroll_sel_ctrl.sv | 102 ++++++++++
 3 files changed

// File: rtl/scroll_pkg.sv
// Shared types and helpers for the HEX message scroll-position sequencer.
// Eight rotation positions; next_pos() returns the wrapped neighbour and whether it wrapped.
package scroll_pkg;

  localparam int SEL_W   = 3;
  localparam int NUM_POS = 8;

  typedef enum logic {
    PAUSE = 1'b0,
    RUN   = 1'b1
  } scroll_state_t;

  typedef struct packed {
    logic [SEL_W-1:0] pos;
    logic             wrap;
  } next_pos_t;

  function automatic next_pos_t next_pos(input logic [SEL_W-1:0] sel,
                                         input logic             dir);
    next_pos_t r;
    if (dir) begin
      r.pos  = sel - 1'b1;
      r.wrap = (sel == '0);
    end else begin
      r.pos  = sel + 1'b1;
      r.wrap = (sel == SEL_W'(NUM_POS - 1));
    end
    return r;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: counts 0..TICK_DIV-1 while enabled and flags the terminal count.
// Held at zero while disabled; clr restarts the period from zero.
module tick_prescaler #(
  parameter int TICK_DIV = 12_500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int                CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr || !en) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // tick is consumed by the owner on the same edge that wraps cnt back to 0
  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/scroll_sel_ctrl.sv
// Timed scroll-position sequencer feeding the HEX7..HEX0 rotator select.
// Auto-advances every TICK_DIV cycles in RUN; single-steps on step rises in PAUSE; load overrides.
module scroll_sel_ctrl
  import scroll_pkg::*;
#(
  parameter int TICK_DIV = 12_500_000
) (
  input  logic             CLOCK_50,
  input  logic             rst,
  input  logic             run,
  input  logic             dir,
  input  logic             step,
  input  logic             load,
  input  logic [SEL_W-1:0] load_pos,
  output logic [SEL_W-1:0] sel,
  output logic             adv,
  output logic             wrap,
  output logic             running
);

  scroll_state_t    state;
  scroll_state_t    state_next;
  logic             state_chg;
  logic             step_d;
  logic             step_rise;
  logic             tick;
  logic             advance;
  next_pos_t        np;
  logic [SEL_W-1:0] sel_next;
  logic             adv_next;
  logic             wrap_next;
  logic             running_next;

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state <= PAUSE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      PAUSE:   if (run)  state_next = RUN;
      RUN:     if (!run) state_next = PAUSE;
      default: state_next = PAUSE;
    endcase
  end

  assign state_chg = (state != state_next);

  // Loading the live step level on reset keeps a step held through reset from counting as a rise.
  always_ff @(posedge CLOCK_50) begin
    step_d <= step;
  end

  assign step_rise = step && !step_d;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk  (CLOCK_50),
    .rst  (rst),
    .en   (state == RUN),
    .clr  (state_chg || load),
    .tick (tick)
  );

  assign advance = ((state == RUN) && tick) || ((state == PAUSE) && step_rise);
  assign np      = next_pos(sel, dir);

  // load wins over an advance on the same edge and the advance is dropped outright
  always_comb begin
    sel_next     = sel;
    adv_next     = 1'b0;
    wrap_next    = 1'b0;
    running_next = (state_next == RUN);
    if (load) begin
      sel_next = load_pos;
    end else if (advance) begin
      sel_next  = np.pos;
      adv_next  = 1'b1;
      wrap_next = np.wrap;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      sel     <= '0;
      adv     <= 1'b0;
      wrap    <= 1'b0;
      running <= 1'b0;
    end else begin
      sel     <= sel_next;
      adv     <= adv_next;
      wrap    <= wrap_next;
      running <= running_next;
    end
  end

endmodule
